// File: rtl/color_pixel_counter.sv
// Per-frame red/blue pixel counter for RGB332 camera pixels; presents registered,
// saturating totals at each VSYNC falling edge and honours a synchronous clear.
module color_pixel_counter #(
  parameter int CNT_W    = 10,
  parameter int RED_MIN  = 5,
  parameter int BLUE_MIN = 2
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [7:0]       PIXEL_IN,
  input  logic             PIXEL_VALID,
  input  logic             VGA_VSYNC_NEG,
  input  logic [1:0]       CLEAR,
  output logic [CNT_W-1:0] REDCOUNT,
  output logic [CNT_W-1:0] BLUECOUNT,
  output logic             COUNT_VALID
);

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } pixel_t;

  typedef enum logic [1:0] {WAIT_SYNC, COUNT, BLANK} state_t;

  localparam logic [2:0]       RED_MIN_F  = RED_MIN[2:0];
  localparam logic [1:0]       BLUE_MIN_F = BLUE_MIN[1:0];
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  pixel_t           pix;
  state_t           state;
  logic             vsync_q, sync_armed;
  logic             rise, fall, is_red, is_blue, clr, qual;
  logic [CNT_W-1:0] red_acc, blue_acc;
  logic             green_unused;

  assign pix          = pixel_t'(PIXEL_IN);
  assign green_unused = &{1'b0, pix.g};

  assign rise    = ~vsync_q &  VGA_VSYNC_NEG;
  assign fall    =  vsync_q & ~VGA_VSYNC_NEG;
  assign is_red  = (pix.r >= RED_MIN_F)  && (pix.b <  BLUE_MIN_F);
  assign is_blue = (pix.b >= BLUE_MIN_F) && (pix.r <  RED_MIN_F);
  assign clr     = |CLEAR;
  assign qual    = PIXEL_VALID & VGA_VSYNC_NEG;

  // sync_armed blocks a "rise" right after reset when VSYNC was already high:
  // vsync_q resets low, so that edge is not a real frame start.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= WAIT_SYNC;
      vsync_q     <= 1'b0;
      sync_armed  <= 1'b0;
      red_acc     <= '0;
      blue_acc    <= '0;
      REDCOUNT    <= '0;
      BLUECOUNT   <= '0;
      COUNT_VALID <= 1'b0;
    end else begin
      vsync_q     <= VGA_VSYNC_NEG;
      COUNT_VALID <= 1'b0;
      if (!VGA_VSYNC_NEG) sync_armed <= 1'b1;

      case (state)
        WAIT_SYNC: if (rise && sync_armed) state <= COUNT;
        COUNT: begin
          if (fall) begin
            REDCOUNT    <= red_acc;
            BLUECOUNT   <= blue_acc;
            red_acc     <= '0;
            blue_acc    <= '0;
            COUNT_VALID <= 1'b1;
            state       <= BLANK;
          end else if (qual) begin
            if (is_red  && red_acc  != CNT_MAX) red_acc  <= red_acc  + CNT_W'(1);
            if (is_blue && blue_acc != CNT_MAX) blue_acc <= blue_acc + CNT_W'(1);
          end
        end
        BLANK:     if (rise) state <= COUNT;
        default:   state <= WAIT_SYNC;
      endcase

      // Clear overrides any latch or pixel update in the same cycle
      if (clr) begin
        red_acc     <= '0;
        blue_acc    <= '0;
        REDCOUNT    <= '0;
        BLUECOUNT   <= '0;
        COUNT_VALID <= 1'b0;
      end
    end
  end

endmodule
